if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage: the head of the f-d-e-m-w pipeline.
- Generates the PC stream and drives a synchronous instruction SRAM (1-cycle read latency).
- Transmitter side of the stage handshake: it sources goon_valid/instruction/pc and obeys the decode stage's allowin.
- Accepts branch redirects (with delay slot) and exception redirects (squashing).

Parameters:
RESET_PC, 32'hBFC00000, first fetch address after reset
EXC_CODE_ADEL, 3'd4, value driven on sig_exc for a misaligned fetch

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
post_allowin  in  1  decode stage can accept this cycle
goon_valid  out  1  instruction/pc valid toward decode
instruction  out  32  fetched instruction word
pc  out  32  address of the instruction
sig_exc  out  3  0 = none, EXC_CODE_ADEL = misaligned fetch
br_taken  in  1  taken branch/jump resolved in decode (1-cycle pulse)
br_target  in  32  branch target, valid with br_taken
exc_redirect  in  1  exception/eret redirect from writeback (pulse)
exc_target  in  32  redirect address, valid with exc_redirect
inst_sram_en  out  1  read enable
inst_sram_addr  out  32  read address (word-aligned)
inst_sram_rdata  in  32  data for the address issued the previous cycle; undefined otherwise

Behaviour:
- State registers:
  - is_valid, reg_pc: the stage register.
  - npc: next sequential fetch address.
  - fresh: SRAM data arrives this cycle.
  - inst_buf: held instruction.
  - br_pend, br_tgt: deferred branch.
  - adel.
- Reset (async, reset=0) values:
  - is_valid=0, fresh=0, br_pend=0, adel=0, npc=RESET_PC.
  - Outputs: goon_valid=0, inst_sram_en=0, sig_exc=0, pc=0, instruction=0.
- allowin = !is_valid || post_allowin. The stage is always ready_go, since data is present the cycle after issue.
- issue = allowin || exc_redirect.
- Issue address, highest priority first: exc_target if exc_redirect; else br_tgt if br_pend; else br_target if br_taken; else npc.
- On issue, at the clock edge:
  - reg_pc <= issue address; is_valid <= 1; npc <= issue address + 4 (32-bit wrap).
  - fresh <= 1 and inst_sram_en = 1, combinationally that cycle. Exception: if issue address[1:0] != 0, set inst_sram_en = 0, adel <= 1, fresh <= 0.
  - br_pend <= 0.
- br_taken while !issue: br_pend <= 1, br_tgt <= br_target. The delay-slot instruction currently held is NOT squashed.
- exc_redirect always issues, even when post_allowin = 0:
  - The current instruction is discarded.
  - goon_valid is forced 0 in that cycle.
  - br_pend is cleared.
  - An exc_redirect and a br_taken in the same cycle: exception wins and the branch is dropped.
- Output data:
  - instruction = inst_sram_rdata if fresh, else inst_buf.
  - instruction = 0 when adel.
  - If fresh && !post_allowin: inst_buf <= inst_sram_rdata.
  - fresh clears on any cycle with no issue.
- goon_valid = is_valid && !exc_redirect.
- sig_exc = adel ? EXC_CODE_ADEL : 0. adel is cleared on the next issue of an aligned address.
- Holding: while post_allowin = 0 (no exc), pc, instruction and sig_exc are held stable; no SRAM read is issued.
- Throughput: with post_allowin held at 1, one instruction per cycle. First goon_valid is the 1st cycle after reset release plus one issue cycle.

Decomposition:
- Shared package cpu_defs holds:
  - RESET_PC and EXC_CODE_ADEL constants;
  - the sig_exc encoding, shared with the decode and writeback stages.
- No sub-module; the next-PC mux and hold buffer are small enough to inline.

Test Plan:
1. Reset release, post_allowin=1, SRAM model returns addr: sram addrs are BFC00000, BFC00004, BFC00008; goon_valid high from the 2nd cycle; pc/instruction pairs match.
2. Stall: post_allowin=0 for 3 cycles while pc=BFC00004. inst_sram_en=0; instruction stays SRAM[BFC00004] although rdata changes to X. Resume fetches BFC00008.
3. Branch with delay slot: br_taken with target 80000100 while pc=BFC00004. BFC00008 (delay slot) is still delivered, then 80000100.
4. Branch while stalled: br_taken during post_allowin=0. The fetch after the stall releases is br_tgt, after the held delay slot.
5. Exception during stall: exc_redirect (target BFC00380) with post_allowin=0. goon_valid=0 that cycle; next delivered pc=BFC00380. Repeat with br_taken in the same cycle: the branch is ignored.
6. Misaligned: br_target=80000102. inst_sram_en=0; delivered pc=80000102, instruction=0, sig_exc=EXC_CODE_ADEL. Async reset asserted mid-stream: goon_valid=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_defs.sv
// Definitions shared by the pipeline stages: reset vector and the exception
// code carried alongside each instruction.
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ADEL = 3'd4
    } exc_code_t;

    localparam logic [2:0] EXC_CODE_ADEL = EXC_ADEL;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, synchronous instruction SRAM access,
// branch (delay-slot) and exception redirects, and the valid/allowin handshake.
module if_stage #(
    parameter logic [31:0] RESET_PC      = cpu_defs::RESET_PC,
    parameter logic [2:0]  EXC_CODE_ADEL = cpu_defs::EXC_CODE_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        post_allowin,
    output logic        goon_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [2:0]  sig_exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic        is_valid;
    logic        fresh;
    logic        br_pend;
    logic        adel;
    logic [31:0] reg_pc;
    logic [31:0] npc;
    logic [31:0] inst_buf;
    logic [31:0] br_tgt;

    logic        allowin;
    logic        issue;
    logic        misaligned;
    logic [31:0] issue_addr;

    always_comb begin
        allowin = !is_valid || post_allowin;
        issue   = allowin || exc_redirect;
        // Exception beats a deferred branch, which beats a fresh branch.
        if (exc_redirect) begin
            issue_addr = exc_target;
        end else if (br_pend) begin
            issue_addr = br_tgt;
        end else if (br_taken) begin
            issue_addr = br_target;
        end else begin
            issue_addr = npc;
        end
        misaligned = |issue_addr[1:0];
    end

    // Gating with the (active-low) reset keeps the SRAM idle while held in reset.
    assign inst_sram_en   = reset && issue && !misaligned;
    assign inst_sram_addr = {issue_addr[31:2], 2'b00};

    assign goon_valid  = is_valid && !exc_redirect;
    assign pc          = reg_pc;
    assign instruction = adel ? 32'd0 : (fresh ? inst_sram_rdata : inst_buf);
    assign sig_exc     = adel ? EXC_CODE_ADEL : cpu_defs::EXC_NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_valid <= 1'b0;
            fresh    <= 1'b0;
            br_pend  <= 1'b0;
            adel     <= 1'b0;
            reg_pc   <= 32'd0;
            npc      <= RESET_PC;
            inst_buf <= 32'd0;
            br_tgt   <= 32'd0;
        end else begin
            if (issue) begin
                reg_pc   <= issue_addr;
                is_valid <= 1'b1;
                npc      <= issue_addr + 32'd4;
                br_pend  <= 1'b0;
                adel     <= misaligned;
                fresh    <= !misaligned;
            end else begin
                fresh <= 1'b0;
                // Branch resolved while stalled: remember it until the next issue.
                if (br_taken) begin
                    br_pend <= 1'b1;
                    br_tgt  <= br_target;
                end
            end
            // SRAM data is only present for one cycle; hold it across a stall.
            if (fresh && !post_allowin) begin
                inst_buf <= inst_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a stream-level model of
// the delivered pc/instruction sequence.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic        post_allowin;
    logic        goon_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [2:0]  sig_exc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    // Stream model: item currently presented (have/cur) and a deferred branch.
    logic        have;
    logic [31:0] cur;
    logic        pend_v;
    logic [31:0] pend;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .post_allowin    (post_allowin),
        .goon_valid      (goon_valid),
        .instruction     (instruction),
        .pc              (pc),
        .sig_exc         (sig_exc),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .exc_redirect    (exc_redirect),
        .exc_target      (exc_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic is_aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

    // Synchronous SRAM: data is garbage unless a read was issued last cycle.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_presented();
        check("pc", pc, cur);
        check("instruction", instruction, is_aligned(cur) ? mem_word(cur) : 32'd0);
        check("sig_exc", {29'd0, sig_exc}, is_aligned(cur) ? 32'd0 : 32'd4);
    endtask

    task automatic check_fetch(input logic [31:0] a);
        check("sram_en", {31'd0, inst_sram_en}, {31'd0, is_aligned(a)});
        if (is_aligned(a)) check("sram_addr", inst_sram_addr, a);
    endtask

    // Called at posedge+1: drive, check at negedge, advance past the next edge.
    task automatic step(input logic pa, input logic br, input logic [31:0] bt,
                        input logic exc, input logic [31:0] et);
        logic [31:0] nxt;
        post_allowin = pa;
        br_taken     = br;
        br_target    = bt;
        exc_redirect = exc;
        exc_target   = et;
        @(negedge clk);
        check("goon_valid", {31'd0, goon_valid}, {31'd0, have && !exc});
        if (exc) begin
            check_fetch(et);
            cur    = et;
            have   = 1'b1;
            pend_v = 1'b0;
        end else if (have && pa) begin
            check_presented();
            nxt = br ? bt : (pend_v ? pend : cur + 32'd4);
            check_fetch(nxt);
            $display("deliver pc=%h inst=%h exc=%0d next=%h", pc, instruction, sig_exc, nxt);
            cur    = nxt;
            pend_v = 1'b0;
        end else if (have) begin
            check_presented();
            check("stall_sram_en", {31'd0, inst_sram_en}, 32'd0);
            if (br) begin
                pend_v = 1'b1;
                pend   = bt;
            end
        end else begin
            check_fetch(cur);
            have = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_goon_valid", {31'd0, goon_valid}, 32'd0);
        check("rst_sram_en", {31'd0, inst_sram_en}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_sig_exc", {29'd0, sig_exc}, 32'd0);
    endtask

    task automatic model_reset();
        have   = 1'b0;
        cur    = RST_PC;
        pend_v = 1'b0;
        pend   = 32'd0;
    endtask

    initial begin
        logic        pa;
        logic        br;
        logic        exc;
        logic [31:0] bt;
        logic [31:0] et;

        reset        = 1'b0;
        post_allowin = 1'b0;
        br_taken     = 1'b0;
        br_target    = 32'd0;
        exc_redirect = 1'b0;
        exc_target   = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;

        // Sequential fetch, then a 3-cycle stall with pc=BFC00004.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Branch resolved in decode while the delay slot is presented.
        step(1, 1, 32'h8000_0100, 0, 0);
        step(1, 0, 0, 0, 0);
        // Branch resolved while stalled.
        step(0, 1, 32'h8000_0200, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Exception during stall, then exception together with a branch.
        step(0, 0, 0, 1, 32'hBFC0_0380);
        step(0, 1, 32'h8000_0300, 1, 32'hBFC0_0380);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Misaligned branch target, hold it, then realign via exception.
        step(1, 1, 32'h8000_0102, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'hBFC0_0380);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Asynchronous reset asserted mid-cycle.
        #2;
        reset        = 1'b0;
        post_allowin = 1'b0;
        br_taken     = 1'b0;
        exc_redirect = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            pa  = ($urandom % 4) != 0;
            exc = have && (($urandom % 16) == 0);
            br  = have && !pend_v && (($urandom % 5) == 0);
            bt  = {16'h8000, $urandom_range(0, 16'hFFFF)};
            bt[1:0] = (($urandom % 8) == 0) ? 2'b10 : 2'b00;
            et  = {16'hBFC0, $urandom_range(0, 16'hFFFF)};
            et[1:0] = 2'b00;
            step(pa, br, bt, exc, et);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
